if_id_queue: RTL and testbench
==============================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: queue entries; legal values are powers of two, 2..16.
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h00000000: instruction driven to decode when the queue is empty.
REQ-003 The block SHALL have port clk  input  1  single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port fetch_valid  input  1  fetch stage presents an instruction this cycle.
REQ-006 The block SHALL have port fetch_instr  input  32  fetched instruction word.
REQ-007 The block SHALL have port fetch_PC_plus_1  input  32  PC+1 associated with fetch_instr.
REQ-008 The block SHALL have port fetch_ready  output  1  queue can accept an entry; fetch holds its PC when this is low.
REQ-009 The block SHALL have port flush  input  1  taken branch or jump (PC_src); discards all queued entries.
REQ-010 The block SHALL have port dec_ready  input  1  decode consumes the head entry; low during a data hazard.
REQ-011 The block SHALL have port dec_valid  output  1  head entry is valid.
REQ-012 The block SHALL have port dec_instr  output  32  head instruction, or NOP_INSTR when the queue is empty.
REQ-013 The block SHALL have port dec_PC_plus_1  output  32  head PC+1, or 32'h0 when the queue is empty.

Function
REQ-014 The block SHALL implement a circular FIFO of DEPTH entries, each holding {instr, PC_plus_1}, with read pointer, write pointer and count registers.
REQ-015 The count register SHALL be clog2(DEPTH)+1 bits wide, and both pointers SHALL wrap modulo DEPTH.
REQ-016 A push SHALL occur on a rising edge when fetch_valid=1, fetch_ready=1 and flush=0.
REQ-017 A pop SHALL occur on a rising edge when dec_valid=1, dec_ready=1 and flush=0.
REQ-018 fetch_ready SHALL equal (count != DEPTH), decoded combinationally from the count register only; it SHALL NOT be bypassed by a same-cycle pop.
REQ-019 dec_valid SHALL equal (count != 0), and dec_instr and dec_PC_plus_1 SHALL be driven from the entry at the read pointer.
REQ-020 Latency: an entry pushed at edge N SHALL appear on the dec_* outputs after edge N when the queue was empty, giving one cycle of fetch-to-decode latency.
REQ-021 A simultaneous push and pop SHALL leave the count unchanged, advance both pointers, and preserve entry order.
REQ-022 Entries SHALL be delivered strictly in push order, with no loss or duplication.
REQ-023 When the queue is full, fetch_valid SHALL be ignored and the stored contents SHALL NOT be altered.
REQ-024 When the queue is empty, dec_ready SHALL have no effect.
REQ-025 When flush=1 at an edge, count and both pointers SHALL become 0, and any same-cycle push or pop SHALL be discarded.
REQ-026 Flush SHALL take priority over all other events.
REQ-027 The storage array SHALL need no clearing on flush; validity SHALL be defined by count alone.

Reset
REQ-028 Asserting rst SHALL immediately, without waiting for clk, set count, read pointer and write pointer to 0.
REQ-029 During reset, fetch_ready SHALL be 1, dec_valid SHALL be 0, dec_instr SHALL be NOP_INSTR and dec_PC_plus_1 SHALL be 32'h0.
REQ-030 Storage contents after reset SHALL be don't-care and SHALL NOT be observable on any output.
REQ-031 Assertion of rst during any combination of push, pop or flush SHALL override them.
REQ-032 The first push SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-033 With IFQ_STALL_STAT_EN defined, the block SHALL add port stall_cnt  output  16  count of cycles with fetch_valid=1 and fetch_ready=0.
REQ-034 stall_cnt SHALL saturate at 16'hFFFF, SHALL be cleared to 0 only by rst, and SHALL NOT be affected by flush.
REQ-035 Without IFQ_STALL_STAT_EN, the stall_cnt port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 The bench SHALL cover: reset, then 3 pushes (instr A1/A2/A3, PC+1 1/2/3) with dec_ready=0 -> count 3, dec_instr=A1, dec_PC_plus_1=1, fetch_ready=1.
REQ-037 The bench SHALL cover: DEPTH=4 fill with dec_ready=0 -> fetch_ready=0 after the 4th push; a 5th fetch_valid is ignored; draining yields the 4 entries in order, then dec_valid=0 and dec_instr=NOP_INSTR.
REQ-038 The bench SHALL cover: continuous push and pop with fetch_valid=dec_ready=1 for 20 cycles -> count stays 1, with one-cycle latency, and the output sequence equals the input sequence across pointer wrap.
REQ-039 The bench SHALL cover: flush with 3 entries queued while a push is presented -> next cycle dec_valid=0, fetch_ready=1, and the pushed entry never appears.
REQ-040 The bench SHALL cover: rst asserted mid-cycle between edges with 2 entries queued -> dec_valid drops to 0 before the next clk edge.
REQ-041 The bench SHALL cover, with IFQ_STALL_STAT_EN defined: 10 cycles of fetch_valid=1 against a full queue -> stall_cnt=10; a subsequent flush leaves stall_cnt=10.

Source files
------------

// File: rtl/if_id_queue.sv
// if_id_queue: circular FIFO of {instr, PC_plus_1} entries between the fetch
// and decode stages. An empty queue presents NOP_INSTR / 32'h0 to decode, and
// a flush (taken branch or jump) empties the queue in one edge.
// Optional feature: define IFQ_STALL_STAT_EN to add the 16-bit saturating
// stall_cnt output (cycles with fetch_valid=1 while the queue is full).
module if_id_queue #(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
`ifdef IFQ_STALL_STAT_EN
   output logic [15:0] stall_cnt,
`endif
   input  logic        fetch_valid,
   input  logic [31:0] fetch_instr,
   input  logic [31:0] fetch_PC_plus_1,
   output logic        fetch_ready,
   input  logic        flush,
   input  logic        dec_ready,
   output logic        dec_valid,
   output logic [31:0] dec_instr,
   output logic [31:0] dec_PC_plus_1
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   // Entry storage; no reset, validity is carried by count_reg alone.
   logic [31:0] instr_mem [DEPTH];
   logic [31:0] pc_mem    [DEPTH];

   logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [CW-1:0] count_reg,  count_next;

   logic push;
   logic pop;

   // Handshake flags come from the count register only, so a pop in the
   // same cycle never makes room for a push.
   assign fetch_ready = (count_reg != CW'(DEPTH));
   assign dec_valid   = (count_reg != '0);

   assign push = fetch_valid & fetch_ready & ~flush;
   assign pop  = dec_valid   & dec_ready   & ~flush;

   // Head entry is read asynchronously so a push is visible one edge later;
   // an empty queue shows the NOP and a zero PC+1 regardless of stale data.
   always_comb begin
      dec_instr     = NOP_INSTR;
      dec_PC_plus_1 = 32'h0;
      if (dec_valid) begin
         dec_instr     = instr_mem[rd_ptr_reg];
         dec_PC_plus_1 = pc_mem[rd_ptr_reg];
      end
   end

   // Next-state for pointers and occupancy; flush wins over push and pop.
   always_comb begin
      rd_ptr_next = rd_ptr_reg;
      wr_ptr_next = wr_ptr_reg;
      count_next  = count_reg;
      if (flush) begin
         rd_ptr_next = '0;
         wr_ptr_next = '0;
         count_next  = '0;
      end else begin
         if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
         endcase
      end
   end

   // Pointer and count registers, cleared immediately by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         rd_ptr_reg <= rd_ptr_next;
         wr_ptr_reg <= wr_ptr_next;
         count_reg  <= count_next;
      end
   end

   // Per-entry write enables; a full queue never rewrites its contents.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == PW'(gi))) begin
               instr_mem[gi] <= fetch_instr;
               pc_mem[gi]    <= fetch_PC_plus_1;
            end
         end
      end
   endgenerate

`ifdef IFQ_STALL_STAT_EN
   // Saturating count of fetch cycles blocked by a full queue; flush-immune.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= 16'h0;
      end else if (fetch_valid && !fetch_ready && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'h1;
      end
   end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: table-driven vectors, hand-written corner sequences and a
// randomized run against a queue-based reference model for if_id_queue.
// Define IFQ_STALL_STAT_EN to also exercise the stall_cnt output.
module tb_if_id_queue;

   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_valid = 1'b0;
   logic [31:0] fetch_instr = '0;
   logic [31:0] fetch_PC_plus_1 = '0;
   logic        fetch_ready;
   logic        flush = 1'b0;
   logic        dec_ready = 1'b0;
   logic        dec_valid;
   logic [31:0] dec_instr;
   logic [31:0] dec_PC_plus_1;
`ifdef IFQ_STALL_STAT_EN
   logic [15:0] stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   if_id_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
      .clk             (clk),
      .rst             (rst),
`ifdef IFQ_STALL_STAT_EN
      .stall_cnt       (stall_cnt),
`endif
      .fetch_valid     (fetch_valid),
      .fetch_instr     (fetch_instr),
      .fetch_PC_plus_1 (fetch_PC_plus_1),
      .fetch_ready     (fetch_ready),
      .flush           (flush),
      .dec_ready       (dec_ready),
      .dec_valid       (dec_valid),
      .dec_instr       (dec_instr),
      .dec_PC_plus_1   (dec_PC_plus_1)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fv;
      logic [31:0] instr;
      logic [31:0] pc;
      logic        fl;
      logic        dr;
      logic        efr;
      logic        edv;
      logic [31:0] ei;
      logic [31:0] ep;
   } vec_t;

   typedef struct {
      logic [31:0] i;
      logic [31:0] p;
   } ent_t;

   vec_t vq[$];
   ent_t mq[$];
   int   stall_model = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_outs(input string name, input logic efr, input logic edv,
                           input logic [31:0] ei, input logic [31:0] ep);
      chk({name, ".fetch_ready"},   32'(fetch_ready),   32'(efr));
      chk({name, ".dec_valid"},     32'(dec_valid),     32'(edv));
      chk({name, ".dec_instr"},     dec_instr,          ei);
      chk({name, ".dec_PC_plus_1"}, dec_PC_plus_1,      ep);
   endtask

   task automatic drive(input logic fv, input logic [31:0] ins, input logic [31:0] pc,
                        input logic fl, input logic dr);
      fetch_valid     = fv;
      fetch_instr     = ins;
      fetch_PC_plus_1 = pc;
      flush           = fl;
      dec_ready       = dr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic fv, input logic [31:0] ins, input logic [31:0] pc,
                      input logic fl, input logic dr, input logic efr, input logic edv,
                      input logic [31:0] ei, input logic [31:0] ep);
      vec_t v;
      v.fv = fv; v.instr = ins; v.pc = pc; v.fl = fl; v.dr = dr;
      v.efr = efr; v.edv = edv; v.ei = ei; v.ep = ep;
      vq.push_back(v);
   endtask

   initial begin
      // Vector table: inputs for one edge, expected outputs after it.
      add(1, 32'hA000_0001, 1, 0, 0,  1, 1, 32'hA000_0001, 1);
      add(1, 32'hA000_0002, 2, 0, 0,  1, 1, 32'hA000_0001, 1);
      add(1, 32'hA000_0003, 3, 0, 0,  1, 1, 32'hA000_0001, 1);
      add(1, 32'hA000_0004, 4, 0, 0,  0, 1, 32'hA000_0001, 1);
      add(1, 32'hA000_0005, 5, 0, 0,  0, 1, 32'hA000_0001, 1);
      add(1, 32'hA000_0006, 6, 0, 1,  1, 1, 32'hA000_0002, 2);
      add(0, 32'h0,         0, 0, 1,  1, 1, 32'hA000_0003, 3);
      add(0, 32'h0,         0, 0, 1,  1, 1, 32'hA000_0004, 4);
      add(0, 32'h0,         0, 0, 1,  1, 0, NOP,           0);
      add(0, 32'h0,         0, 0, 1,  1, 0, NOP,           0);
      add(1, 32'hB000_0001, 11, 0, 0, 1, 1, 32'hB000_0001, 11);
      add(1, 32'hB000_0002, 12, 0, 0, 1, 1, 32'hB000_0001, 11);
      add(1, 32'hB000_0003, 13, 0, 0, 1, 1, 32'hB000_0001, 11);
      add(1, 32'hB000_0004, 14, 1, 1, 1, 0, NOP,           0);
      add(0, 32'h0,         0, 0, 1,  1, 0, NOP,           0);

      // Reset state, observed with no clock edge involved.
      #3;
      chk_outs("reset", 1'b1, 1'b0, NOP, 32'h0);
      tick();
      tick();
      rst = 1'b0;

      foreach (vq[k]) begin
         drive(vq[k].fv, vq[k].instr, vq[k].pc, vq[k].fl, vq[k].dr);
         tick();
         $display("vec %0d fv=%0b fl=%0b dr=%0b -> fr=%0b dv=%0b instr=%h pc=%0d",
                  k, vq[k].fv, vq[k].fl, vq[k].dr, fetch_ready, dec_valid, dec_instr, dec_PC_plus_1);
         chk_outs($sformatf("vec%0d", k), vq[k].efr, vq[k].edv, vq[k].ei, vq[k].ep);
      end

      // Streaming push+pop for 20 cycles; pointers wrap several times.
      for (int i = 0; i < 20; i++) begin
         drive(1, 32'hC000_0000 + 32'(i), 32'(100 + i), 0, 1);
         tick();
         $display("stream %0d head=%h", i, dec_instr);
         chk_outs($sformatf("stream%0d", i), 1'b1, 1'b1, 32'hC000_0000 + 32'(i), 32'(100 + i));
      end
      drive(0, 0, 0, 0, 1);
      tick();
      chk_outs("stream_drain", 1'b1, 1'b0, NOP, 32'h0);

`ifdef IFQ_STALL_STAT_EN
      // Stall statistics: 10 blocked cycles, then a flush must not clear them.
      drive(0, 0, 0, 0, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("stall_reset", 32'(stall_cnt), 32'd0);
      for (int i = 0; i < 4; i++) begin
         drive(1, 32'hD000_0000 + 32'(i), 32'(200 + i), 0, 0);
         tick();
      end
      chk("stall_full_ready", 32'(fetch_ready), 32'd0);
      for (int i = 0; i < 10; i++) begin
         drive(1, 32'hDEAD_0000 + 32'(i), 32'(300 + i), 0, 0);
         tick();
      end
      drive(0, 0, 0, 0, 0);
      $display("stall count after 10 blocked cycles = %0d", stall_cnt);
      chk("stall_cnt10", 32'(stall_cnt), 32'd10);
      chk_outs("stall_head", 1'b0, 1'b1, 32'hD000_0000, 32'd200);
      drive(0, 0, 0, 1, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      chk("stall_after_flush", 32'(stall_cnt), 32'd10);
      chk_outs("stall_flush", 1'b1, 1'b0, NOP, 32'h0);
`endif

      // Asynchronous reset mid-cycle with two entries queued.
      drive(1, 32'hE000_0001, 21, 0, 0);
      tick();
      drive(1, 32'hE000_0002, 22, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      chk_outs("pre_async", 1'b1, 1'b1, 32'hE000_0001, 21);
      #3;
      rst = 1'b1;
      #1;
      $display("async reset asserted mid-cycle dv=%0b", dec_valid);
      chk_outs("async_rst", 1'b1, 1'b0, NOP, 32'h0);
`ifdef IFQ_STALL_STAT_EN
      chk("async_rst_stall", 32'(stall_cnt), 32'd0);
`endif
      #2;
      rst = 1'b0;
      drive(1, 32'hE000_0003, 23, 0, 0);
      tick();
      chk_outs("first_push_after_rst", 1'b1, 1'b1, 32'hE000_0003, 23);
      drive(0, 0, 0, 1, 0);
      tick();
      chk_outs("pre_random_flush", 1'b1, 1'b0, NOP, 32'h0);

      // Randomized traffic against a queue model.
      mq.delete();
      stall_model = 0;
      for (int c = 0; c < 400; c++) begin
         logic        fv, fl, dr;
         logic [31:0] ins, pc;
         int          n;
         ent_t        e;
         fv  = 1'($urandom_range(0, 3) != 0);
         dr  = 1'($urandom_range(0, 1));
         fl  = 1'($urandom_range(0, 24) == 0);
         ins = $urandom;
         pc  = $urandom;
         drive(fv, ins, pc, fl, dr);
         n = mq.size();
         if (fv && n == DEPTH && stall_model < 65535) stall_model++;
         tick();
         if (fl) begin
            mq.delete();
         end else begin
            if (dr && n > 0) void'(mq.pop_front());
            if (fv && n < DEPTH) begin
               e.i = ins;
               e.p = pc;
               mq.push_back(e);
            end
         end
         if (mq.size() > 0)
            chk_outs($sformatf("rand%0d", c), 1'(mq.size() != DEPTH), 1'b1, mq[0].i, mq[0].p);
         else
            chk_outs($sformatf("rand%0d", c), 1'b1, 1'b0, NOP, 32'h0);
`ifdef IFQ_STALL_STAT_EN
         chk($sformatf("rand%0d.stall_cnt", c), 32'(stall_cnt), 32'(stall_model));
`endif
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
